// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM encoding and slice geometry.
package serial_adder_pkg;

  // Number of operand bits consumed per ADD cycle.
  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_slice_2bit.sv
// Two-bit ripple full adder: the only arithmetic element of the serial adder.
module adder_slice_2bit (
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic       cin,
  output logic [1:0] sum,
  output logic       cout
);

  logic c1;

  // Bit 0 generates the internal carry that ripples into bit 1.
  assign sum[0] = x[0] ^ y[0] ^ cin;
  assign c1     = (x[0] & y[0]) | (cin & (x[0] ^ y[0]));
  assign sum[1] = x[1] ^ y[1] ^ c1;
  assign cout   = (x[1] & y[1]) | (c1 & (x[1] ^ y[1]));

endmodule

// File: rtl/serial_adder_seq.sv
// Serial adder: adds a + b + cin two bits per cycle, LSB slice first.
//
// Handshake: start is sampled on a rising edge only in IDLE or DONE; when
// sampled high there, a/b/cin are captured on that same edge and busy rises
// for exactly WIDTH/2 cycles. done then pulses for one cycle while sum/cout
// already show the new result. start is ignored while busy is high.
module serial_adder_seq
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output state_e           state_dbg_o
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [1:0]       slice_sum;
  logic             slice_cout;
  logic             accept;
  logic             last_slice;

  // A new request is taken only when no addition is in flight.
  assign accept     = start && (state_q != ST_ADD);
  assign last_slice = (state_q == ST_ADD) && (cnt_q == LAST_SLICE);

  adder_slice_2bit u_slice (
    .x    (a_sh_q[1:0]),
    .y    (b_sh_q[1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: IDLE/DONE accept a request, ADD runs WIDTH/2 cycles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_ADD;
      ST_ADD:  if (cnt_q == LAST_SLICE) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_ADD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; result outputs come straight from registers.
  always_comb begin
    busy        = (state_q == ST_ADD);
    done        = (state_q == ST_DONE);
    sum         = sum_q;
    cout        = cout_q;
    state_dbg_o = state_q;
  end

  // Datapath next values: capture on accept, shift one slice per ADD cycle.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      res_d   = '0;
      cnt_d   = '0;
      carry_d = cin;
    end else if (state_q == ST_ADD) begin
      a_sh_d  = a_sh_q >> SLICE_W;
      b_sh_d  = b_sh_q >> SLICE_W;
      res_d   = {slice_sum, res_q[WIDTH-1:SLICE_W]};
      cnt_d   = cnt_q + CNT_W'(1);
      carry_d = slice_cout;
      // Publish only the completed word so partial sums never appear.
      if (last_slice) begin
        sum_d  = {slice_sum, res_q[WIDTH-1:SLICE_W]};
        cout_d = slice_cout;
      end
    end
  end

  // Datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq (WIDTH=8).
module tb_serial_adder_seq;
  import serial_adder_pkg::*;

  localparam int W    = 8;
  localparam int HALF = W / 2;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  state_e       state_dbg;

  always #5 clk = ~clk;

  serial_adder_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .busy        (busy),
    .done        (done),
    .sum         (sum),
    .cout        (cout),
    .state_dbg_o (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];
  logic [W:0] mon_e;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", {31'd0, done}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", {23'd0, cout, sum}, {23'd0, mon_e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present operands with start and push the expected result at the accepting edge.
  task automatic accept_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(x, y, c));
  endtask

  // Drop start, scramble operands, and run until the FSM is back in IDLE.
  task automatic finish_op();
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    repeat (HALF) @(posedge clk);
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  logic [W-1:0] bx[4];
  logic [W-1:0] by[4];
  logic         bc[4];

  initial begin
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_sum",   {24'd0, sum},  32'd0);
    check("rst_cout",  {31'd0, cout}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    rst = 1'b0; start = 1'b0;

    // 5A + 3C: busy for four cycles, done on the fifth, result then held.
    accept_op(8'h5A, 8'h3C, 1'b0);
    for (int i = 0; i < HALF; i++) begin
      @(negedge clk);
      check("lat_busy", {31'd0, busy}, 32'd1);
      check("lat_done", {31'd0, done}, 32'd0);
      start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end
    @(negedge clk);
    check("lat_done_pulse", {31'd0, done}, 32'd1);
    check("lat_busy_off",   {31'd0, busy}, 32'd0);
    check("lat_sum",        {24'd0, sum},  32'h96);
    check("lat_cout",       {31'd0, cout}, 32'd0);
    @(negedge clk);
    check("post_done", {31'd0, done}, 32'd0);
    check("post_busy", {31'd0, busy}, 32'd0);
    check("hold_sum",  {24'd0, sum},  32'h96);

    // Carry ripple through all slices and the all-ones corner.
    accept_op(8'hFF, 8'h01, 1'b0); finish_op();
    accept_op(8'hFF, 8'hFF, 1'b1); finish_op();
    accept_op(8'h00, 8'h00, 1'b0); finish_op();
    accept_op(8'h00, 8'h00, 1'b1); finish_op();
    accept_op(8'h80, 8'h80, 1'b0); finish_op();

    // start during ADD is ignored.
    accept_op(8'h10, 8'h20, 1'b0);
    @(negedge clk); start = 1'b0; a = 8'h00; b = 8'h00;
    @(negedge clk); start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    check("ign_sum", {24'd0, sum}, 32'h30);

    // Reset at the second edge of an operation aborts it.
    accept_op(8'hAA, 8'h55, 1'b1);
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    void'(exp_q.pop_back());
    @(negedge clk);
    check("abort_busy",  {31'd0, busy}, 32'd0);
    check("abort_done",  {31'd0, done}, 32'd0);
    check("abort_sum",   {24'd0, sum},  32'd0);
    check("abort_cout",  {31'd0, cout}, 32'd0);
    check("abort_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_hold_sum", {24'd0, sum}, 32'd0);
    accept_op(8'h12, 8'h34, 1'b1); finish_op();

    // Reset and start together: reset wins.
    @(negedge clk); rst = 1'b1; start = 1'b1; a = 8'h77; b = 8'h11;
    @(negedge clk);
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk);

    // Back-to-back: start held high, done every HALF+1 cycles.
    bx = '{8'h01, 8'hC3, 8'hFF, 8'h7E};
    by = '{8'h02, 8'h3C, 8'h01, 8'h81};
    bc = '{1'b0, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    a = bx[0]; b = by[0]; cin = bc[0]; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      exp_q.push_back(model(bx[k], by[k], bc[k]));
      @(negedge clk);
      check("b2b_busy", {31'd0, busy}, 32'd1);
      if (k < 3) begin
        a = bx[k+1]; b = by[k+1]; cin = bc[k+1];
      end else begin
        start = 1'b0;
      end
      repeat (HALF) @(posedge clk);
      @(negedge clk);
      check("b2b_done", {31'd0, done}, 32'd1);
    end
    @(posedge clk);

    // Random operations with operand churn and stray start during ADD.
    for (int n = 0; n < 16; n++) begin
      accept_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)));
      repeat (HALF) begin
        @(negedge clk);
        start = 1'($urandom_range(0, 1));
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      @(negedge clk); start = 1'b0;
      @(posedge clk);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    check("drain", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_seq.md
SERIAL_ADDER_SEQ -- requirements
Module: serial_adder_seq

Interface
- REQ-001: Parameter WIDTH, default 8: operand width in bits; SHALL be even and >= 4.
- REQ-002: clk  input  1  sole clock; all state changes on rising edge.
- REQ-003: rst  input  1  reset; synchronous and active-high.
- REQ-004: start  input  1  request to begin an addition, sampled on rising edge.
- REQ-005: a  input  WIDTH  operand A, captured when start is accepted.
- REQ-006: b  input  WIDTH  operand B, captured when start is accepted.
- REQ-007: cin  input  1  carry-in, captured when start is accepted.
- REQ-008: busy  output  1  high while an addition is in progress.
- REQ-009: done  output  1  single-cycle pulse marking a new result.
- REQ-010: sum  output  WIDTH  result bits, registered.
- REQ-011: cout  output  1  final carry-out, registered.

Function
- REQ-012: Block SHALL add a + b + cin two bits per cycle, LSB slice first, through one 2-bit full-adder slice and a carry flip-flop.
- REQ-013: FSM SHALL have states IDLE, ADD, DONE.
- REQ-014: IDLE: start=1 at an edge SHALL capture a, b and cin into internal shift registers, clear the slice counter, load the carry flip-flop with cin, and enter ADD.
- REQ-015: ADD: each edge SHALL process slice k (bits 2k+1:2k), store its 2 sum bits, load the carry flip-flop with the slice carry, and increment k.
- REQ-016: ADD SHALL last exactly WIDTH/2 cycles; on the edge processing the last slice, the FSM SHALL enter DONE and load sum/cout from the completed result.
- REQ-017: DONE: done=1 for exactly one cycle; the next edge SHALL return to IDLE, or, if start=1, capture new operands and enter ADD (back-to-back).
- REQ-018: Latency: with start accepted at edge t, done SHALL be high in the cycle after edge t+WIDTH/2 (cycle t+5 for WIDTH=8).
- REQ-019: busy SHALL be 1 in ADD only and 0 in IDLE and DONE.
- REQ-020: start SHALL be ignored while in ADD; operands and the computation SHALL be unaffected.
- REQ-021: sum/cout SHALL hold the last completed result until the next completion, and SHALL never show partial results.
- REQ-022: Arithmetic SHALL be unsigned modulo 2^WIDTH, with cout as bit WIDTH of the true sum.
- REQ-023: Changes on a, b or cin after capture SHALL NOT affect the in-flight result.

Reset
- REQ-024: rst=1 at an edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, carry and shift registers.
- REQ-025: Reset SHALL take priority over start, including in the same cycle.
- REQ-026: Reset during ADD SHALL abort the operation: done SHALL NOT pulse, and sum SHALL stay 0.

Structure
- REQ-027: The state encoding (IDLE/ADD/DONE) and the slice-width constant (2) SHALL live in a shared package, serial_adder_pkg.
- REQ-028: The 2-bit ripple full adder SHALL be a sub-module, adder_slice_2bit (ports: x[1:0], y[1:0], cin, sum[1:0], cout), instantiated exactly once.
- REQ-029: The slice counter SHALL be ceil(log2(WIDTH/2)) bits wide.

Verification (WIDTH=8)
- REQ-030: a=8'h5A, b=8'h3C, cin=0, start at edge t -> busy high for cycles t+1..t+4; done at t+5; sum=8'h96, cout=0.
- REQ-031: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (carry ripples through all four slices).
- REQ-032: a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- REQ-033: Start with a=8'h10, b=8'h20, then start=1 with a=8'hFF, b=8'hFF at t+2 -> second request ignored; result sum=8'h30, cout=0.
- REQ-034: rst=1 at t+2 of an operation -> next cycle busy=0, sum=0, cout=0; no done pulse; a fresh start then completes normally.
- REQ-035: start held high through DONE -> a new operation begins without an IDLE cycle; done pulses every 5 cycles with the correct results.
